// File: rtl/ascensor_pkg.sv
// Shared elevator definitions: direction encoding, default floor count and
// the request-code map used by the request register, control FSM and display.
package ascensor_pkg;

  localparam logic DIR_SUBE    = 1'b0;
  localparam logic DIR_BAJA    = 1'b1;
  localparam int   N_PISOS_DEF = 32'sd4;

  function automatic int code_cabina(input int k);
    return k;
  endfunction

  function automatic int code_sube(input int k, input int n = N_PISOS_DEF);
    return n + (32'sd2 * k) - 32'sd1;
  endfunction

  // Down calls sit just below the up call of the same floor, so codes stay dense.
  function automatic int code_baja(input int k, input int n = N_PISOS_DEF);
    return n + (32'sd2 * k) - 32'sd2;
  endfunction

endpackage

// File: rtl/antirrebote.sv
// One button line: two-flop synchroniser followed by a counting debouncer that
// accepts a level only after DEBOUNCE_CYCLES consecutive differing samples.
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic boton,
  output logic db,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_r;
  logic             sync_r;
  logic             db_r;
  logic [CNT_W-1:0] cnt_r;
  logic             differ_s;
  logic             accept_s;

  // Two-flop synchroniser for the asynchronous board input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= boton;
      sync_r <= meta_r;
    end
  end

  // Acceptance decode: the level flips on the last of the stable cycles.
  always_comb begin
    differ_s = (sync_r != db_r);
    accept_s = differ_s && (cnt_r == CNT_MAX);
  end

  // Stability counter and accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_r  <= 1'b0;
      cnt_r <= '0;
    end else if (accept_s) begin
      db_r  <= sync_r;
      cnt_r <= '0;
    end else if (differ_s) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= '0;
    end
  end

  assign db = db_r;
  // Combinational so the pending bit can latch on the same edge db rises.
  assign rise = accept_s && sync_r;

endmodule

// File: rtl/registro_solicitudes.sv
// Elevator request register: debounced buttons set persistent pending bits,
// service clears drop them, and the lowest pending code is published.
module registro_solicitudes
  import ascensor_pkg::*;
#(
  parameter  int N_PISOS         = N_PISOS_DEF,
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int PISO_W          = $clog2(N_PISOS),
  localparam int CODE_W          = $clog2(3 * N_PISOS - 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PISOS-1:0] piso,
  input  logic [N_PISOS-2:0] sube,
  input  logic [N_PISOS-2:0] baja,
  input  logic               clr_en,
  input  logic [PISO_W-1:0]  clr_piso,
  input  logic               clr_dir,
  output logic [N_PISOS-1:0] cab_pend,
  output logic [N_PISOS-2:0] sube_pend,
  output logic [N_PISOS-2:0] baja_pend,
  output logic [CODE_W-1:0]  boton_pres,
  output logic               hay_solicitud
);

  localparam int NL = 3 * N_PISOS - 2;

  logic [NL-1:0]      boton_s;
  logic [NL-1:0]      db_s;
  logic [NL-1:0]      rise_s;
  logic [NL-1:0]      set_s;
  logic [N_PISOS-1:0] cab_pend_r, cab_clr_s;
  logic [N_PISOS-2:0] sube_pend_r, sube_clr_s;
  logic [N_PISOS-2:0] baja_pend_r, baja_clr_s;
  logic [CODE_W-1:0]  code_s;
  logic [CODE_W-1:0]  boton_pres_r;
  logic               hay_r;

  assign boton_s = {baja, sube, piso};

  for (genvar g = 0; g < NL; g++) begin : g_line
    antirrebote #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_antirrebote (
      .clk  (clk),
      .rst_n(rst_n),
      .boton(boton_s[g]),
      .db   (db_s[g]),
      .rise (rise_s[g])
    );
  end

  assign set_s = rise_s & ~db_s;

  // Clear decode; an out-of-range floor matches no bit.
  always_comb begin
    cab_clr_s  = '0;
    sube_clr_s = '0;
    baja_clr_s = '0;
    for (int i = 0; i < N_PISOS; i++) begin
      cab_clr_s[i] = clr_en && (int'(clr_piso) == i);
    end
    for (int i = 0; i < N_PISOS - 1; i++) begin
      sube_clr_s[i] = clr_en && (int'(clr_piso) == i) && (clr_dir == DIR_SUBE);
      baja_clr_s[i] = clr_en && (int'(clr_piso) == i + 1) && (clr_dir == DIR_BAJA);
    end
  end

  // Pending requests: a new press wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cab_pend_r  <= '0;
      sube_pend_r <= '0;
      baja_pend_r <= '0;
    end else begin
      cab_pend_r  <= (cab_pend_r & ~cab_clr_s) | set_s[N_PISOS-1:0];
      sube_pend_r <= (sube_pend_r & ~sube_clr_s) | set_s[2*N_PISOS-2:N_PISOS];
      baja_pend_r <= (baja_pend_r & ~baja_clr_s) | set_s[NL-1:2*N_PISOS-1];
    end
  end

  // Priority encoder: scan from highest code down so the lowest pending code wins.
  always_comb begin
    code_s = '0;
    for (int i = N_PISOS - 2; i >= 0; i--) begin
      code_s = baja_pend_r[i] ? CODE_W'(code_baja(i + 2, N_PISOS)) : code_s;
      code_s = sube_pend_r[i] ? CODE_W'(code_sube(i + 1, N_PISOS)) : code_s;
    end
    for (int i = N_PISOS - 1; i >= 0; i--) begin
      code_s = cab_pend_r[i] ? CODE_W'(code_cabina(i + 1)) : code_s;
    end
  end

  // Registered summary outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boton_pres_r <= '0;
      hay_r        <= 1'b0;
    end else begin
      boton_pres_r <= code_s;
      hay_r        <= |{cab_pend_r, sube_pend_r, baja_pend_r};
    end
  end

  assign cab_pend      = cab_pend_r;
  assign sube_pend     = sube_pend_r;
  assign baja_pend     = baja_pend_r;
  assign boton_pres    = boton_pres_r;
  assign hay_solicitud = hay_r;

endmodule
